// File: rtl/light_seq_ctrl.sv
// light_seq_ctrl
//   Sequencing controller for a light pattern generator. Selects one of three
//   modes (sel 00/01/10), emits a periodic one-cycle step strobe and pulses a
//   pattern reset whenever the mode changes. A mode advance comes from a
//   rising edge of the conditioned button, or from the dwell counter when
//   auto cycling is enabled.
//
// Parameters
//   CLK_DIV     clocks per step strobe (>= 2)
//   DWELL_STEPS steps spent in each mode while auto cycling (>= 1)
//   DEB_CYCLES  consecutive high samples needed to qualify the button (>= 2)
//
// Build option
//   DEBOUNCE_EN  when defined, the synchronized button must stay high for
//                DEB_CYCLES samples before it counts as pressed; otherwise the
//                synchronized level is used directly and DEB_CYCLES is unused.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   btn_next in   raw asynchronous button, advances the mode
//   auto_en  in   level, enables dwell-based auto advance
//   pause    in   level, freezes step generation (button still works)
//   sel      out  [1:0] registered mode select
//   step     out  registered one-cycle step strobe
//   pat_rst  out  registered pattern generator reset (high in INIT/SWITCH)
module light_seq_ctrl #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned DWELL_STEPS = 16,
  parameter int unsigned DEB_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       auto_en,
  input  logic       pause,
  output logic [1:0] sel,
  output logic       step,
  output logic       pat_rst
);

  localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DW = (DWELL_STEPS > 1) ? $clog2(DWELL_STEPS + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(CLK_DIV - 2);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_STEPS - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_SWITCH
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_sel;
  logic [1:0]    w_sel_nxt;
  logic          r_step;
  logic          w_step_nxt;
  logic          r_pat_rst;
  logic          w_pat_rst_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic [DW-1:0] r_dwell;
  logic [DW-1:0] w_dwell_nxt;
  logic          r_pend;
  logic          w_pend_nxt;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_btn_prev;
  logic          w_btn_cond;
  logic          w_btn_edge;
  logic          w_dwell_req;
  logic          w_adv;

  // Two-flop synchronizer plus previous conditioned level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_sync1    <= btn_next;
      r_sync2    <= r_sync1;
      r_btn_prev <= w_btn_cond;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] r_deb_cnt;
  logic          r_deb;

  // Qualified high once DEB_CYCLES consecutive high samples have been seen;
  // any low sample drops it immediately and restarts the count.
  always_ff @(posedge clk) begin
    if (rst || !r_sync2) begin
      r_deb_cnt <= '0;
      r_deb     <= 1'b0;
    end else if (r_deb_cnt == DEB_LAST) begin
      r_deb     <= 1'b1;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_btn_cond = r_deb;
`else
  assign w_btn_cond = r_sync2;
`endif

  assign w_btn_edge = w_btn_cond & ~r_btn_prev;

  // Outputs are registered from next-state values, so step is scheduled one
  // cycle ahead: it is loaded while the prescaler sits at CLK_DIV-2 and is
  // visible in the cycle the prescaler reads CLK_DIV-1.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_step_nxt    = 1'b0;
    w_pat_rst_nxt = 1'b1;
    w_presc_nxt   = r_presc;
    w_dwell_nxt   = r_dwell;
    w_pend_nxt    = r_pend;
    w_dwell_req   = 1'b0;
    w_adv         = 1'b0;

    case (r_state)
      ST_INIT: begin
        w_state_nxt   = ST_RUN;
        w_pat_rst_nxt = 1'b0;
        w_presc_nxt   = '0;
        w_dwell_nxt   = '0;
        w_pend_nxt    = 1'b0;
      end

      ST_SWITCH: begin
        w_state_nxt   = ST_RUN;
        w_pat_rst_nxt = 1'b0;
        w_presc_nxt   = '0;
        w_dwell_nxt   = '0;
        // A press during the switch is held over and served on the first RUN cycle.
        if (w_btn_edge) begin
          w_pend_nxt = 1'b1;
        end
      end

      ST_RUN: begin
        // The step already on the output is counted even if pause rose in
        // that same cycle; pause only stops new steps from being issued.
        if (!auto_en) begin
          w_dwell_nxt = '0;
        end else if (r_step) begin
          if (r_dwell == DWELL_LAST) begin
            w_dwell_req = 1'b1;
            w_dwell_nxt = '0;
          end else begin
            w_dwell_nxt = r_dwell + 1'b1;
          end
        end

        // Coinciding sources collapse into a single advance.
        w_adv = w_btn_edge | w_dwell_req | r_pend;

        if (w_adv) begin
          w_state_nxt   = ST_SWITCH;
          w_sel_nxt     = (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
          w_pend_nxt    = 1'b0;
          w_pat_rst_nxt = 1'b1;
        end else begin
          w_pat_rst_nxt = 1'b0;
          if (!pause) begin
            w_presc_nxt = (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
            w_step_nxt  = (r_presc == PRESC_PRE);
          end
        end
      end

      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_sel     <= '0;
      r_step    <= 1'b0;
      r_pat_rst <= 1'b1;
      r_presc   <= '0;
      r_dwell   <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_step    <= w_step_nxt;
      r_pat_rst <= w_pat_rst_nxt;
      r_presc   <= w_presc_nxt;
      r_dwell   <= w_dwell_nxt;
      r_pend    <= w_pend_nxt;
    end
  end

  assign sel     = r_sel;
  assign step    = r_step;
  assign pat_rst = r_pat_rst;

endmodule

// File: tb/tb_light_seq_ctrl.sv
// Testbench for light_seq_ctrl (CLK_DIV=4, DWELL_STEPS=3, DEB_CYCLES=8).
// Directed scenarios with literal expectations, then randomized stimulus,
// all cross-checked every cycle against a behavioural model.
module tb_light_seq_ctrl;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DWELL   = 3;
  localparam int unsigned DEB     = 8;
`ifdef DEBOUNCE_EN
  localparam bit          DEB_ON  = 1'b1;
  localparam int unsigned LAT     = 2 + DEB;
`else
  localparam bit          DEB_ON  = 1'b0;
  localparam int unsigned LAT     = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_next = 1'b0;
  logic       auto_en = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] sel;
  logic       step;
  logic       pat_rst;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  light_seq_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .DWELL_STEPS(DWELL),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_next(btn_next),
    .auto_en (auto_en),
    .pause   (pause),
    .sel     (sel),
    .step    (step),
    .pat_rst (pat_rst)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The pattern generator is either held in reset for one cycle (after reset
  // or after a mode change) or running. Running time is tracked as a count of
  // unpaused cycles since the last restart; a step falls on every CLK_DIV-th.
  bit         m_valid = 1'b0;
  bit         m_held;
  bit         m_from_rst;
  int         m_sel;
  bit         m_step;
  int         m_elapsed;
  int         m_steps_seen;
  bit         m_pend;
  bit         m_s1, m_s2, m_prev;
  int         m_hi;

  always @(posedge clk) begin
    bit cond;
    bit press;
    bit dwell_hit;
    if (rst) begin
      m_valid = 1'b1; m_held = 1'b1; m_from_rst = 1'b1; m_sel = 0; m_step = 1'b0;
      m_elapsed = 0; m_steps_seen = 0; m_pend = 1'b0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_prev = 1'b0; m_hi = 0;
    end else begin
      cond   = DEB_ON ? (m_hi >= DEB) : m_s2;
      press  = cond && !m_prev;
      m_prev = cond;
      if (m_s2) m_hi = (m_hi >= DEB) ? DEB : m_hi + 1;
      else      m_hi = 0;
      m_s2 = m_s1;
      m_s1 = btn_next;
      if (m_held) begin
        if (!m_from_rst && press) m_pend = 1'b1;
        m_held = 1'b0; m_from_rst = 1'b0;
        m_elapsed = 0; m_steps_seen = 0; m_step = 1'b0;
      end else begin
        dwell_hit = 1'b0;
        if (!auto_en) m_steps_seen = 0;
        else if (m_step) begin
          m_steps_seen++;
          if (m_steps_seen == DWELL) begin
            dwell_hit = 1'b1;
            m_steps_seen = 0;
          end
        end
        if (press || dwell_hit || m_pend) begin
          m_sel = (m_sel + 1) % 3;
          m_held = 1'b1; m_step = 1'b0; m_pend = 1'b0;
        end else if (!pause) begin
          m_elapsed++;
          m_step = ((m_elapsed % CLK_DIV) == CLK_DIV - 1);
        end else begin
          m_step = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_sel", {30'd0, sel}, m_sel);
      chk("model_step", {31'd0, step}, {31'd0, m_step});
      chk("model_pat_rst", {31'd0, pat_rst}, {31'd0, m_held});
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    rst = 1'b1;
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sel", {30'd0, sel}, 0);
    chk("rst_step", {31'd0, step}, 0);
    chk("rst_pat_rst", {31'd0, pat_rst}, 1);
    rst = 1'b0;  // this cycle is the single INIT cycle
  endtask

  // Press the button, return the cycle (relative to the press) where pat_rst
  // first rises and the sel shown then. Stops at that SWITCH cycle.
  task automatic press_wait(input int hold, input int bound,
                            output int at, output logic [1:0] s);
    at = -1;
    s  = 2'd3;
    btn_next = 1'b1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (i == hold) btn_next = 1'b0;
      if (pat_rst) begin
        at = i;
        s  = sel;
        break;
      end
    end
    if (at < 0) begin
      errors++;
      $display("FAIL press_timeout: no advance within %0d cycles", bound);
    end
  endtask

  initial begin
    int         n;
    int         at;
    logic [1:0] s;
    int         hold_left;
    int         pulses;

    // A: reset release, INIT cycle then steps every 4th cycle
    auto_en = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("run_step", {31'd0, step}, ((i % 4) == 0) ? 1 : 0);
      chk("run_pat_rst", {31'd0, pat_rst}, 0);
    end

    // B: auto cycling 00->01->10->00, 3 steps per mode plus one switch cycle
    auto_en = 1'b1;
    do_reset();
    for (int m = 1; m <= 3; m++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!pat_rst && n < 40);
      chk("auto_period", n, 13);
      chk("auto_sel", {30'd0, sel}, m % 3);
    end

    // C: button edge coinciding with the 3rd dwell step -> single advance
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 12 - LAT) btn_next = 1'b1;
      if (i == 24 - LAT) btn_next = 1'b0;
      if (i == 12) chk("coin_third_step", {31'd0, step}, 1);
      if (i == 13) begin
        chk("coin_sel", {30'd0, sel}, 1);
        chk("coin_pat_rst", {31'd0, pat_rst}, 1);
      end
      if (i > 13) begin
        chk("coin_hold_sel", {30'd0, sel}, 1);
        chk("coin_no_2nd", {31'd0, pat_rst}, 0);
      end
    end
    auto_en = 1'b0;
    btn_next = 1'b0;

    // D: pause freezes steps and prescaler; button still advances
    do_reset();
    for (int i = 1; i <= 4; i++) @(negedge clk);
    chk("pre_pause_step", {31'd0, step}, 1);
    pause = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      chk("pause_step", {31'd0, step}, 0);
      if (j == 20) pause = 1'b0;
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("resume_step", {31'd0, step}, (k == 4) ? 1 : 0);
    end
    pause = 1'b1;
    press_wait(12, 40, at, s);
    chk("pause_btn_lat", at, LAT + 1);
    chk("pause_btn_sel", {30'd0, s}, 1);
    btn_next = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk("pause_step_after", {31'd0, step}, 0);
    end
    pause = 1'b0;

    // E: reset asserted during SWITCH with sel=10
    do_reset();
    press_wait(12, 40, at, s);
    chk("btn_lat", at, LAT + 1);
    chk("btn_sel1", {30'd0, s}, 1);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    press_wait(12, 40, at, s);
    chk("btn_sel2", {30'd0, s}, 2);
    btn_next = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midsw_rst_sel", {30'd0, sel}, 0);
    chk("midsw_rst_pat", {31'd0, pat_rst}, 1);
    chk("midsw_rst_step", {31'd0, step}, 0);
    rst = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      chk("post_rst_sel", {30'd0, sel}, 0);
      chk("post_rst_pat", {31'd0, pat_rst}, 0);
    end

    // F: short glitches are rejected only when the debouncer is built in
    if (DEB_ON) begin
      do_reset();
      pulses = 0;
      for (int g = 0; g < 3; g++) begin
        btn_next = 1'b1;
        repeat (3) begin @(negedge clk); if (pat_rst) pulses++; end
        btn_next = 1'b0;
        repeat (3) begin @(negedge clk); if (pat_rst) pulses++; end
      end
      repeat (20) begin @(negedge clk); if (pat_rst) pulses++; end
      chk("glitch_adv", pulses, 0);
      btn_next = 1'b1;
      repeat (12) begin @(negedge clk); if (pat_rst) pulses++; end
      btn_next = 1'b0;
      repeat (30) begin @(negedge clk); if (pat_rst) pulses++; end
      chk("press12_adv", pulses, 1);
      chk("press12_sel", {30'd0, sel}, 1);
    end

    // G: randomized stimulus against the model
    do_reset();
    hold_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      if (hold_left == 0) begin
        btn_next  = ~btn_next;
        hold_left = $urandom_range(1, DEB_ON ? 20 : 8);
      end else begin
        hold_left--;
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
